pmu_counter_arbiter: RTL and testbench
======================================

Name: pmu_counter_arbiter

Overview:
- Shares the single PMU counter-bank read/write port between N_REQ requesters, for example the AXI PMU bridge and the overflow/snapshot engine.
- Uses a round-robin policy, one outstanding bank access at a time.
- Drives the bank-side level handshake: enable is held until valid, then dropped, then the block waits for valid to fall.
- Adds a watchdog timeout that returns an error completion, so a dead bank cannot hang the requesters.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- COUNTER_ADDRESS_WIDTH, 16, counter address width.
- COUNTER_DATA_WIDTH, 64, counter data width.
- TIMEOUT_CYCLES, 1024, cycles to wait for bank valid before an error completion (≥2).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request; held high until done.
- req_write  in  N_REQ  1=write, 0=read.
- req_addr  in  N_REQ*COUNTER_ADDRESS_WIDTH  packed address, requester i at slice i.
- req_wdata  in  N_REQ*COUNTER_DATA_WIDTH  packed write data.
- req_done  out  N_REQ  one-cycle completion pulse, one-hot.
- req_error  out  1  valid with req_done; 1 = timeout.
- req_rdata  out  COUNTER_DATA_WIDTH  read data, valid with req_done.
- counter_read_enable  out  1  bank read request (level).
- counter_read_valid  in  1  bank read complete (level, already synchronous to S_AXI_ACLK).
- counter_read_address  out  COUNTER_ADDRESS_WIDTH.
- counter_read_data  in  COUNTER_DATA_WIDTH.
- counter_write_enable  out  1  bank write request (level).
- counter_write_valid  in  1  bank write complete (level).
- counter_write_address  out  COUNTER_ADDRESS_WIDTH.
- counter_write_data  out  COUNTER_DATA_WIDTH.

Behaviour:
- Reset (asynchronous, S_AXI_ARESETN low):
  - All outputs 0.
  - State IDLE, priority pointer = 0, timeout counter = 0.
  - Reset mid-transaction drops enable immediately; no done pulse is generated.
- State machine IDLE / BUSY / RELEASE.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Latch grant index, write flag, address and data into the bank-side outputs.
  - Assert counter_write_enable or counter_read_enable at the next edge; go to BUSY.
  - Grant decision and enable assertion share one edge, so enable rises 1 cycle after req_valid is sampled.
- BUSY:
  - Enable held high; address and data stable; timeout counter increments each cycle.
  - When the matching valid is sampled high, next edge:
    - enable ← 0;
    - req_done[grant] ← 1 for one cycle;
    - req_error ← 0;
    - req_rdata ← counter_read_data for reads, 0 for writes;
    - go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES-1 without valid, next edge:
    - enable ← 0;
    - done pulse with req_error=1 and req_rdata=0;
    - go to RELEASE.
- RELEASE:
  - Wait until the valid of the completed operation type is sampled low, then go to IDLE.
  - Timeout case: valid is already low, so this takes 1 cycle.
  - Prevents a stale high valid from completing the next access.
- Pointer update: on done, pointer ← (grant+1) mod N_REQ. Applies to timeouts as well.
- Requester contract:
  - Deassert req_valid in the cycle after req_done, or keep it high to request again.
  - The arbiter does not re-sample a requester's fields while it is granted.
- req_rdata and req_error hold their values until the next done pulse.
- Never both enables high; at most one req_done bit high.
- Changes to req_valid of non-granted requesters during BUSY have no effect.
- Bank-side outputs are registered.
- Minimum turnaround from request to done: 3 cycles with a 1-cycle bank.
- Back-to-back throughput: 1 access per 4 cycles.
- Timeout counter width is $clog2(TIMEOUT_CYCLES); it is cleared on every entry to BUSY.

Test Plan:
- Single read: req_valid=2'b01, write=0, addr=16'h0010; bank raises read_valid 2 cycles after enable with data 64'hDEAD_BEEF → read_enable high until valid, address=16'h0010, req_done=2'b01 pulse, req_rdata=64'hDEAD_BEEF, error=0.
- Single write: requester 1 write addr=16'h0008, wdata=64'h5 → write_enable with address/data 16'h0008/64'h5, read_enable stays 0, req_done=2'b10, req_rdata=0.
- Contention: both requesters hold req_valid for 4 transactions from reset → grant order 0,1,0,1, done pulses alternate, never two enables.
- Stale valid: bank holds write_valid high for 3 cycles after enable drops, requester 0 requests again → the second write_enable rises only after write_valid is low.
- Timeout: TIMEOUT_CYCLES=8, bank never responds → enable drops, done with req_error=1, req_rdata=0 at cycle 8 of BUSY; the next requester is granted afterwards.
- Reset mid-BUSY: assert S_AXI_ARESETN low while read_enable=1 → all outputs 0 asynchronously, no req_done; after release, arbitration starts from requester 0.

Source files
------------

// File: rtl/pmu_counter_arbiter.sv
// Round-robin arbiter sharing the PMU counter-bank port between N_REQ requesters,
// with a level enable/valid bank handshake and a watchdog that returns an error completion.
module pmu_counter_arbiter #(
    parameter int N_REQ                 = 2,
    parameter int COUNTER_ADDRESS_WIDTH = 16,
    parameter int COUNTER_DATA_WIDTH    = 64,
    parameter int TIMEOUT_CYCLES        = 1024
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESETN,
    input  logic [N_REQ-1:0]                      req_valid,
    input  logic [N_REQ-1:0]                      req_write,
    input  logic [N_REQ*COUNTER_ADDRESS_WIDTH-1:0] req_addr,
    input  logic [N_REQ*COUNTER_DATA_WIDTH-1:0]    req_wdata,
    output logic [N_REQ-1:0]                      req_done,
    output logic                                  req_error,
    output logic [COUNTER_DATA_WIDTH-1:0]         req_rdata,
    output logic                                  counter_read_enable,
    input  logic                                  counter_read_valid,
    output logic [COUNTER_ADDRESS_WIDTH-1:0]      counter_read_address,
    input  logic [COUNTER_DATA_WIDTH-1:0]         counter_read_data,
    output logic                                  counter_write_enable,
    input  logic                                  counter_write_valid,
    output logic [COUNTER_ADDRESS_WIDTH-1:0]      counter_write_address,
    output logic [COUNTER_DATA_WIDTH-1:0]         counter_write_data
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int AW    = COUNTER_ADDRESS_WIDTH;
    localparam int DW    = COUNTER_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant;
    logic             op_write;
    logic [TMO_W-1:0] tmo_cnt;

    logic             any_req;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] next_ptr;
    logic             bank_valid;
    int               idx;

    // Scan from the highest offset down so the first set bit at or after ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (req_valid[idx]) begin
                any_req = 1'b1;
                pick    = IDX_W'(idx);
            end
        end
    end

    assign next_ptr   = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    assign bank_valid = op_write ? counter_write_valid : counter_read_valid;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state                 <= IDLE;
            ptr                   <= '0;
            grant                 <= '0;
            op_write              <= 1'b0;
            tmo_cnt               <= '0;
            req_done              <= '0;
            req_error             <= 1'b0;
            req_rdata             <= '0;
            counter_read_enable   <= 1'b0;
            counter_read_address  <= '0;
            counter_write_enable  <= 1'b0;
            counter_write_address <= '0;
            counter_write_data    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; this default makes req_done a single-cycle pulse.
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= pick;
                        op_write <= req_write[pick];
                        tmo_cnt  <= '0;
                        if (req_write[pick]) begin
                            counter_write_enable  <= 1'b1;
                            counter_write_address <= req_addr[pick*AW +: AW];
                            counter_write_data    <= req_wdata[pick*DW +: DW];
                        end else begin
                            counter_read_enable  <= 1'b1;
                            counter_read_address <= req_addr[pick*AW +: AW];
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bank_valid) begin
                        counter_read_enable  <= 1'b0;
                        counter_write_enable <= 1'b0;
                        req_done[grant]      <= 1'b1;
                        req_error            <= 1'b0;
                        req_rdata            <= op_write ? '0 : counter_read_data;
                        ptr                  <= next_ptr;
                        state                <= RELEASE;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        counter_read_enable  <= 1'b0;
                        counter_write_enable <= 1'b0;
                        req_done[grant]      <= 1'b1;
                        req_error            <= 1'b1;
                        req_rdata            <= '0;
                        ptr                  <= next_ptr;
                        state                <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // A valid still high from the finished access must not complete the next one.
                    if (!bank_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmu_counter_arbiter.sv
// Directed self-checking bench for pmu_counter_arbiter: read, write, stale valid,
// round-robin contention, watchdog timeout and reset in the middle of an access.
module tb_pmu_counter_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid;
    logic [1:0]   req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [1:0]   req_done;
    logic         req_error;
    logic [63:0]  req_rdata;
    logic         rd_en;
    logic         rd_valid;
    logic [15:0]  rd_addr;
    logic [63:0]  rd_data;
    logic         wr_en;
    logic         wr_valid;
    logic [15:0]  wr_addr;
    logic [63:0]  wr_data;

    int tests = 0;
    int fails = 0;
    int cyc;

    always #5 clk = ~clk;

    pmu_counter_arbiter #(
        .N_REQ                 (2),
        .COUNTER_ADDRESS_WIDTH (16),
        .COUNTER_DATA_WIDTH    (64),
        .TIMEOUT_CYCLES        (8)
    ) dut (
        .S_AXI_ACLK            (clk),
        .S_AXI_ARESETN         (rst_n),
        .req_valid             (req_valid),
        .req_write             (req_write),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .req_done              (req_done),
        .req_error             (req_error),
        .req_rdata             (req_rdata),
        .counter_read_enable   (rd_en),
        .counter_read_valid    (rd_valid),
        .counter_read_address  (rd_addr),
        .counter_read_data     (rd_data),
        .counter_write_enable  (wr_en),
        .counter_write_valid   (wr_valid),
        .counter_write_address (wr_addr),
        .counter_write_data    (wr_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of falling edges until an enable is seen, 0 if none within the bound.
    task automatic wait_en(output int n);
        int i;
        n = 0;
        i = 0;
        while (n == 0 && i < 40) begin
            @(negedge clk);
            i++;
            if (rd_en || wr_en) n = i;
        end
        check("one_enable", 64'(rd_en & wr_en), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        wr_valid  = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_error", 64'(req_error), 64'd0);
        check("rst_rdata", req_rdata, 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read from requester 0, bank answers two cycles into the access
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr  = 32'h0000_0010;
        wait_en(cyc);
        check("rd_latency", 64'(cyc), 64'd1);
        check("rd_en", 64'(rd_en), 64'd1);
        check("rd_wr_en_low", 64'(wr_en), 64'd0);
        check("rd_addr", 64'(rd_addr), 64'h10);
        @(negedge clk);
        check("rd_en_held", 64'(rd_en), 64'd1);
        check("rd_no_early_done", 64'(req_done), 64'd0);
        rd_valid = 1'b1;
        rd_data  = 64'hDEAD_BEEF;
        @(negedge clk);
        check("rd_done", 64'(req_done), 64'b01);
        check("rd_error", 64'(req_error), 64'd0);
        check("rd_rdata", req_rdata, 64'hDEAD_BEEF);
        check("rd_en_drop", 64'(rd_en), 64'd0);
        req_valid = 2'b00;
        rd_valid  = 1'b0;
        rd_data   = '0;
        @(negedge clk);
        check("rd_done_pulse", 64'(req_done), 64'd0);
        check("rd_rdata_hold", req_rdata, 64'hDEAD_BEEF);
        @(negedge clk);

        // Single write from requester 1
        req_valid = 2'b10;
        req_write = 2'b10;
        req_addr  = 32'h0008_0000;
        req_wdata = {64'h5, 64'h0};
        wait_en(cyc);
        check("wr_latency", 64'(cyc), 64'd1);
        check("wr_en", 64'(wr_en), 64'd1);
        check("wr_rd_en_low", 64'(rd_en), 64'd0);
        check("wr_addr", 64'(wr_addr), 64'h8);
        check("wr_data", wr_data, 64'h5);
        wr_valid = 1'b1;
        @(negedge clk);
        check("wr_done", 64'(req_done), 64'b10);
        check("wr_rdata_zero", req_rdata, 64'd0);
        check("wr_error", 64'(req_error), 64'd0);
        check("wr_en_drop", 64'(wr_en), 64'd0);
        req_valid = 2'b00;
        wr_valid  = 1'b0;
        repeat (2) @(negedge clk);

        // Stale write_valid held after enable drops; requester 0 asks again immediately
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr  = 32'h0000_0030;
        req_wdata = {64'h0, 64'h77};
        wait_en(cyc);
        check("stale_latency", 64'(cyc), 64'd1);
        check("stale_wr_addr", 64'(wr_addr), 64'h30);
        check("stale_wr_data", wr_data, 64'h77);
        wr_valid = 1'b1;
        @(negedge clk);
        check("stale_done", 64'(req_done), 64'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stale_hold_en", 64'(wr_en), 64'd0);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("stale_idle_en", 64'(wr_en), 64'd0);
        @(negedge clk);
        check("stale_regrant", 64'(wr_en), 64'd1);
        wr_valid = 1'b1;
        @(negedge clk);
        check("stale_done2", 64'(req_done), 64'b01);
        req_valid = 2'b00;
        wr_valid  = 1'b0;
        repeat (2) @(negedge clk);

        // Contention from reset: grants alternate 0,1,0,1
        do_reset();
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = {16'h0200, 16'h0100};
        for (int k = 0; k < 4; k++) begin
            wait_en(cyc);
            check("rr_latency", 64'(cyc), (k == 0) ? 64'd1 : 64'd2);
            check("rr_addr", 64'(rd_addr), (k % 2 == 1) ? 64'h200 : 64'h100);
            rd_valid = 1'b1;
            rd_data  = 64'hA0 + 64'(k);
            @(negedge clk);
            check("rr_done", 64'(req_done), (k % 2 == 1) ? 64'b10 : 64'b01);
            check("rr_rdata", req_rdata, 64'hA0 + 64'(k));
            rd_valid = 1'b0;
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        // Watchdog: requester 0 read never answered, requester 1 write waits behind it
        req_valid = 2'b11;
        req_write = 2'b10;
        req_addr  = {16'h0050, 16'h0040};
        req_wdata = {64'h99, 64'h0};
        wait_en(cyc);
        check("tmo_latency", 64'(cyc), 64'd1);
        check("tmo_rd_addr", 64'(rd_addr), 64'h40);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("tmo_en_held", 64'(rd_en), 64'd1);
        end
        @(negedge clk);
        check("tmo_done", 64'(req_done), 64'b01);
        check("tmo_error", 64'(req_error), 64'd1);
        check("tmo_rdata", req_rdata, 64'd0);
        check("tmo_en_drop", 64'(rd_en), 64'd0);
        req_valid = 2'b10;
        wait_en(cyc);
        check("tmo_next_latency", 64'(cyc), 64'd2);
        check("tmo_next_wr_en", 64'(wr_en), 64'd1);
        check("tmo_next_addr", 64'(wr_addr), 64'h50);
        check("tmo_next_data", wr_data, 64'h99);
        wr_valid = 1'b1;
        @(negedge clk);
        check("tmo_next_done", 64'(req_done), 64'b10);
        check("tmo_next_error", 64'(req_error), 64'd0);
        req_valid = 2'b00;
        wr_valid  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a read granted to requester 1
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr  = {16'h0070, 16'h0060};
        wait_en(cyc);
        rd_valid = 1'b1;
        rd_data  = 64'h1;
        @(negedge clk);
        check("mid_pre_done", 64'(req_done), 64'b01);
        req_valid = 2'b11;
        rd_valid  = 1'b0;
        wait_en(cyc);
        check("mid_grant1_addr", 64'(rd_addr), 64'h70);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        check("mid_rst_done", 64'(req_done), 64'd0);
        check("mid_rst_rdata", req_rdata, 64'd0);
        @(negedge clk);
        check("mid_rst_no_done", 64'(req_done), 64'd0);
        rst_n = 1'b1;
        wait_en(cyc);
        check("mid_after_latency", 64'(cyc), 64'd1);
        check("mid_after_addr", 64'(rd_addr), 64'h60);
        rd_valid = 1'b1;
        rd_data  = 64'h2;
        @(negedge clk);
        check("mid_after_done", 64'(req_done), 64'b01);
        check("mid_after_rdata", req_rdata, 64'h2);
        req_valid = 2'b00;
        rd_valid  = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
